// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states
// and the fixed-priority helper.
package irq_controller_pkg;

  localparam logic [1:0]  IRQ_PENDING_OFF = 2'd0;
  localparam logic [1:0]  IRQ_ENABLE_OFF  = 2'd1;
  localparam logic [1:0]  IRQ_OVERRUN_OFF = 2'd2;
  localparam logic [1:0]  IRQ_CURRENT_OFF = 2'd3;

  // Window base seen by the system bus decoder; offsets above select within it.
  localparam logic [63:0] IRQ_BASE        = 64'h0000_0000_0001_0000;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PRESENT = 2'd1,
    IRQ_RELEASE = 2'd2
  } irq_state_e;

  // Index of the lowest set bit; callers gate the result with |v.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser with a history flop for rising-edge detection.
module irq_sync_edge
  import irq_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/irq_controller.sv
// N-source interrupt controller: pending/overrun state, fixed-priority arbitration,
// vector presentation FSM and a four-register bus window.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int                 NUM_SRC     = 8,
  parameter int                 VEC_W       = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = '1,
  parameter logic [NUM_SRC-1:0] ENABLE_RST  = NUM_SRC'(1),
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [1:0]         reg_addr,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [63:0]        reg_wdata,
  output logic [63:0]        reg_rdata,
  output logic [VEC_W-1:0]   interrupt_vector,
  input  logic               interrupt_ack,
  output logic               interrupt_pending
);

  logic [NUM_SRC-1:0] w_level, w_rise, w_masked, w_clr, w_pend_nxt;
  logic [NUM_SRC-1:0] w_ovr_set, w_ovr_w1c, w_ack_clr, w_pend_w1c;
  logic [NUM_SRC-1:0] r_pending, r_enable, r_overrun;
  logic [3:0]         w_win, r_idx, w_idx_nxt;
  logic [VEC_W-1:0]   r_vec, w_vec_nxt;
  irq_state_e         r_state, w_state_nxt;
  logic               r_irq_pend;
  logic [63:0]        r_rdata;
  logic               w_unused;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (irq_src[gi]),
        .o_level (w_level[gi]),
        .o_rise  (w_rise[gi])
      );
    end
  endgenerate

  assign w_masked   = r_pending & r_enable;
  assign w_win      = lowest_set(16'(w_masked));
  assign w_ack_clr  = (r_state == IRQ_PRESENT && interrupt_ack) ? (NUM_SRC'(1) << r_idx) : '0;
  assign w_pend_w1c = (reg_we && reg_addr == IRQ_PENDING_OFF) ? reg_wdata[NUM_SRC-1:0] : '0;
  assign w_ovr_w1c  = (reg_we && reg_addr == IRQ_OVERRUN_OFF) ? reg_wdata[NUM_SRC-1:0] : '0;
  // Level sources follow their synced input and cannot be cleared; a new edge beats any clear.
  assign w_clr      = (w_ack_clr | w_pend_w1c) & EDGE_MASK;
  assign w_ovr_set  = w_rise & r_pending & ~w_clr & EDGE_MASK;
  assign w_pend_nxt = (((r_pending & ~w_clr) | w_rise) & EDGE_MASK) | (w_level & ~EDGE_MASK);
  assign w_unused   = ^reg_wdata[63:NUM_SRC];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= '0;
      r_overrun  <= '0;
      r_enable   <= ENABLE_RST;
      r_irq_pend <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_pending  <= w_pend_nxt;
      r_overrun  <= (r_overrun & ~w_ovr_w1c) | w_ovr_set;
      r_irq_pend <= |w_masked;
      if (reg_we && reg_addr == IRQ_ENABLE_OFF) r_enable <= reg_wdata[NUM_SRC-1:0];
      // A simultaneous write takes the bus cycle; read data then holds.
      if (reg_re && !reg_we) begin
        unique case (reg_addr)
          IRQ_PENDING_OFF: r_rdata <= 64'(r_pending);
          IRQ_ENABLE_OFF:  r_rdata <= 64'(r_enable);
          IRQ_OVERRUN_OFF: r_rdata <= 64'(r_overrun);
          IRQ_CURRENT_OFF: r_rdata <= 64'(r_vec);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IRQ_IDLE;
      r_vec   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // RELEASE re-arbitrates directly so the deasserted vector lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IRQ_IDLE, IRQ_RELEASE: begin
        if (|w_masked) begin
          w_state_nxt = IRQ_PRESENT;
          w_idx_nxt   = w_win;
          w_vec_nxt   = VEC_W'(w_win) + VEC_W'(1);
        end else begin
          w_state_nxt = IRQ_IDLE;
          w_vec_nxt   = '0;
        end
      end
      IRQ_PRESENT: begin
        if (interrupt_ack) begin
          w_state_nxt = IRQ_RELEASE;
          w_vec_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IRQ_IDLE;
        w_vec_nxt   = '0;
      end
    endcase
  end

  assign interrupt_vector  = r_vec;
  assign interrupt_pending = r_irq_pend;
  assign reg_rdata         = r_rdata;

endmodule
